fetch_sequencer: RTL

- Controller for the fetch-stage PC register: drives its `en` and `next_pc` inputs every cycle.
- Arbitrates between sequential fetch, branch/jump redirect from ID, exception entry, ERET, and pipeline stall from the hazard unit.
- Buffers a redirect that arrives during a stall and replays it when the stall releases.
- Keeps saturating stall and redirect counters for performance debug.

---
 rtl/fetch_sequencer_pkg.sv | 12 +
 rtl/fetch_sequencer_sat.sv | 19 +
 rtl/fetch_sequencer.sv | 85 ++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared fetch addresses and sequencer state encoding
package fetch_sequencer_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC  = 32'h0000_4180;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/fetch_sequencer_sat.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // count events, holding once the maximum value is reached
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (inc && count != '1)
            count <= count + CNT_W'(1);
    end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: drives PC register enable and next-PC with redirect buffering across stalls
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = fetch_sequencer_pkg::RESET_PC,
    parameter logic [31:0] EXC_VEC  = fetch_sequencer_pkg::EXC_VEC,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_target,
    input  logic             exc_req,
    input  logic             eret_req,
    input  logic [31:0]      epc,
    output logic             pc_en,
    output logic [31:0]      next_pc,
    output logic             pend_valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redir_cnt
);

    import fetch_sequencer_pkg::*;

    state_t      state, state_next;
    logic [31:0] pend_target, pend_next;
    logic        redir_inc;

    // state and buffered redirect target; reset drops any pending redirect at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            pend_target <= '0;
        end else begin
            state       <= state_next;
            pend_target <= pend_next;
        end
    end

    // prioritised next-PC selection: exception, eret, stall, live redirect, replay, sequential
    always_comb begin
        state_next = state;
        pend_next  = pend_target;
        pc_en      = 1'b1;
        next_pc    = pc + 32'd4;
        redir_inc  = 1'b0;
        if (reset) begin
            pc_en   = 1'b0;
            next_pc = RESET_PC;
        end else if (exc_req || eret_req) begin
            next_pc    = exc_req ? EXC_VEC : epc;
            state_next = RUN;
            pend_next  = '0;
        end else if (stall) begin
            pc_en   = 1'b0;
            next_pc = pc;
            if (redirect_valid) begin
                pend_next  = redirect_target;
                state_next = HOLD;
            end
        end else if (redirect_valid || state == HOLD) begin
            next_pc    = redirect_valid ? redirect_target : pend_target;
            redir_inc  = 1'b1;
            state_next = RUN;
            pend_next  = '0;
        end
    end

    assign pend_valid = (state == HOLD);

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_redir_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (redir_inc),
        .count (redir_cnt)
    );

endmodule
